// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Bundle of the sequencer's control, instruction-memory and
//                ALU-side signals. The master modport is the sequencer; the
//                slave modport is the surrounding memory/ALU environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int ADDR_W   = 12,
    parameter int NREG_SEL = 4
);
    logic                start;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_req;
    logic                imem_ack;
    logic [15:0]         imem_data;
    logic [15:0]         instruction;
    logic [3:0]          alu_control;
    logic                Z_in;
    logic [NREG_SEL-1:0] bus_sel;
    logic                reg_we;
    logic                busy;
    logic                halted;

    modport master (
        input  start, imem_ack, imem_data, Z_in,
        output imem_addr, imem_req, instruction, alu_control,
               bus_sel, reg_we, busy, halted
    );

    modport slave (
        output start, imem_ack, imem_data, Z_in,
        input  imem_addr, imem_req, instruction, alu_control,
               bus_sel, reg_we, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Fetch/decode/execute controller for the accumulator ALU.
//                Fetches 16-bit instructions, drives the ALU control code and
//                operand-bus select, performs register writes and jumps.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int RST_PC   = 0,
    parameter int NREG_SEL = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    alu_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] c_rst_pc = ADDR_W'(RST_PC);

    localparam logic [3:0] c_OP_JMP   = 4'hA;
    localparam logic [3:0] c_OP_JMPZ  = 4'hB;
    localparam logic [3:0] c_OP_JMPNZ = 4'hC;
    localparam logic [3:0] c_OP_STAC  = 4'hD;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic [3:0]          r_alu_control;
    logic                r_imem_req;
    logic                r_reg_we;
    logic [NREG_SEL-1:0] r_bus_sel;
    logic                r_busy;
    logic                r_halted;

    logic [3:0]          w_opcode;
    logic                w_is_alu_op;
    logic                w_jump;
    logic [ADDR_W-1:0]   w_target;

    assign w_opcode    = r_ir[15:12];
    assign w_target    = r_ir[ADDR_W-1:0];
    assign w_is_alu_op = (w_opcode >= 4'h1) && (w_opcode <= 4'h9);

    // Jump decision; Z_in is only meaningful while in EXEC
    always_comb begin
        w_jump = 1'b0;
        case (w_opcode)
            c_OP_JMP:   w_jump = 1'b1;
            c_OP_JMPZ:  w_jump = bus.Z_in;
            c_OP_JMPNZ: w_jump = ~bus.Z_in;
            default:    w_jump = 1'b0;
        endcase
    end

    // Sequencer state machine; every output is a register updated on entry to its state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pc          <= c_rst_pc;
            r_ir          <= '0;
            r_alu_control <= '0;
            r_imem_req    <= 1'b0;
            r_reg_we      <= 1'b0;
            r_bus_sel     <= '0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= c_rst_pc;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir       <= bus.imem_data;
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // EXEC-cycle outputs are set up here so they are valid for the whole EXEC cycle
                    r_bus_sel     <= r_ir[NREG_SEL-1:0];
                    r_alu_control <= w_is_alu_op ? w_opcode : 4'h0;
                    r_reg_we      <= (w_opcode == c_OP_STAC);
                    r_state       <= S_EXEC;
                end
                S_EXEC: begin
                    r_alu_control <= 4'h0;
                    r_reg_we      <= 1'b0;
                    if (w_jump) begin
                        r_pc <= w_target;
                    end
                    if (w_opcode == c_OP_HALT) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.imem_req    = r_imem_req;
    assign bus.instruction = r_ir;
    assign bus.alu_control = r_alu_control;
    assign bus.bus_sel     = r_bus_sel;
    assign bus.reg_we      = r_reg_we;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer with a simple
//                instruction-memory responder and a controllable ack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    logic clock;
    logic reset_n;
    logic ack_en;
    logic [15:0] mem [0:4095];
    int   n_checks;
    int   n_pass;

    alu_sequencer_if #(.ADDR_W(12), .NREG_SEL(4)) bus ();

    alu_sequencer #(.ADDR_W(12), .RST_PC(0), .NREG_SEL(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory responder: data always reflects the current address, ack gated by the bench
    assign bus.imem_ack  = bus.imem_req & ack_en;
    assign bus.imem_data = mem[bus.imem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    // One-cycle start pulse; on return the sequencer is in FETCH
    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Run a single instruction at address 0 and check the next fetch address
    task automatic run_branch(input string tag, input logic [15:0] instr, input logic z,
                              input logic [11:0] exp_addr);
        clear_mem();
        mem[0] = instr;
        do_reset();
        bus.Z_in = z;
        pulse_start();
        tick();                       // DECODE
        tick();                       // EXEC
        check({tag, "_exec_alu"}, bus.alu_control, 4'h0);
        check({tag, "_exec_we"},  bus.reg_we, 1'b0);
        tick();                       // next FETCH
        check({tag, "_next_addr"}, bus.imem_addr, exp_addr);
        check({tag, "_next_req"},  bus.imem_req, 1'b1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        ack_en    = 1'b1;
        bus.start = 1'b0;
        bus.Z_in  = 1'b0;
        clear_mem();
        tick();
        tick();

        // Reset state
        check("rst_busy",   bus.busy, 1'b0);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_req",    bus.imem_req, 1'b0);
        check("rst_alu",    bus.alu_control, 4'h0);
        check("rst_we",     bus.reg_we, 1'b0);
        check("rst_sel",    bus.bus_sel, 4'h0);
        check("rst_addr",   bus.imem_addr, 12'h000);
        check("rst_ir",     bus.instruction, 16'h0000);
        reset_n = 1'b1;
        tick();
        check("idle_busy",  bus.busy, 1'b0);

        // Program: LDC 0x005; INC; HALT
        mem[0] = 16'h6005;
        mem[1] = 16'h7000;
        mem[2] = 16'hF000;
        pulse_start();
        check("p1_fetch_req",  bus.imem_req, 1'b1);
        check("p1_fetch_busy", bus.busy, 1'b1);
        check("p1_fetch_addr", bus.imem_addr, 12'h000);
        tick();
        check("p1_dec_ir",     bus.instruction, 16'h6005);
        check("p1_dec_alu",    bus.alu_control, 4'h0);
        check("p1_dec_req",    bus.imem_req, 1'b0);
        tick();
        check("p1_exec_ldc",   bus.alu_control, 4'h6);
        tick();
        check("p1_f2_alu",     bus.alu_control, 4'h0);
        check("p1_f2_addr",    bus.imem_addr, 12'h001);
        tick();
        tick();
        check("p1_exec_inc",   bus.alu_control, 4'h7);
        tick();
        tick();
        check("p1_halt_early", bus.halted, 1'b0);
        tick();
        check("p1_exec_halt_alu", bus.alu_control, 4'h0);
        check("p1_halt_early2",   bus.halted, 1'b0);
        tick();
        check("p1_halted",     bus.halted, 1'b1);
        check("p1_busy",       bus.busy, 1'b0);
        check("p1_pc",         bus.imem_addr, 12'h003);
        check("p1_req",        bus.imem_req, 1'b0);

        // Fetch stall, restart from HALT; then ADD 2
        mem[0] = 16'h1002;
        mem[1] = 16'hF000;
        ack_en = 1'b0;
        pulse_start();
        check("stall_restart_halted", bus.halted, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req",  bus.imem_req, 1'b1);
            check("stall_alu",  bus.alu_control, 4'h0);
            check("stall_addr", bus.imem_addr, 12'h000);
        end
        ack_en = 1'b1;
        tick();
        check("stall_dec_req", bus.imem_req, 1'b0);
        check("stall_dec_ir",  bus.instruction, 16'h1002);
        tick();
        check("add_alu",  bus.alu_control, 4'h1);
        check("add_sel",  bus.bus_sel, 4'h2);
        check("add_we",   bus.reg_we, 1'b0);

        // Conditional and unconditional jumps, reserved opcode
        run_branch("jmpz_t",  16'hB010, 1'b1, 12'h010);
        run_branch("jmpz_n",  16'hB010, 1'b0, 12'h001);
        run_branch("jmpnz_n", 16'hC010, 1'b1, 12'h001);
        run_branch("jmpnz_t", 16'hC010, 1'b0, 12'h010);
        run_branch("jmp",     16'hA010, 1'b0, 12'h010);
        run_branch("resv_e",  16'hE123, 1'b0, 12'h001);
        run_branch("self_jmp",16'hA000, 1'b0, 12'h000);

        // STAC 3: reg_we exactly one cycle
        clear_mem();
        mem[0] = 16'hD003;
        do_reset();
        pulse_start();
        tick();
        check("stac_dec_we", bus.reg_we, 1'b0);
        tick();
        check("stac_we",  bus.reg_we, 1'b1);
        check("stac_sel", bus.bus_sel, 4'h3);
        check("stac_alu", bus.alu_control, 4'h0);
        tick();
        check("stac_we_drop", bus.reg_we, 1'b0);

        // PC wrap: jump to 0xFFF, NOP there, next fetch at 0x000
        clear_mem();
        mem[0]     = 16'hAFFF;
        mem[4095]  = 16'h0000;
        do_reset();
        pulse_start();
        tick();
        tick();
        tick();
        check("wrap_fetch_fff", bus.imem_addr, 12'hFFF);
        tick();
        tick();
        check("wrap_nop_alu", bus.alu_control, 4'h0);
        tick();
        check("wrap_addr", bus.imem_addr, 12'h000);

        // Reset asserted during EXEC of STAC
        clear_mem();
        mem[0] = 16'hD003;
        mem[1] = 16'hD005;
        do_reset();
        pulse_start();
        tick();
        tick();
        check("rst_exec_we_before", bus.reg_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_exec_we",   bus.reg_we, 1'b0);
        check("rst_exec_busy", bus.busy, 1'b0);
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_req",  bus.imem_req, 1'b0);
        check("post_rst_pc",   bus.imem_addr, 12'h000);
        check("post_rst_we",   bus.reg_we, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
